// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// inv_mix_columns_seq: iterative AES InvMixColumns, one 32-bit column per cycle, valid/ready on both sides.
// Optional macro IMC_FWD_MODE_EN adds a per-block fwd_mode input selecting forward MixColumns.
module inv_mix_columns_seq #(
   parameter int NUM_COLS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
`ifdef IMC_FWD_MODE_EN
   input  logic         fwd_mode,
`endif
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int CW = $clog2(NUM_COLS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   col_cnt, col_cnt_nxt;
   logic [127:0]    state_reg, state_reg_nxt;
   logic [127:0]    result_reg, result_reg_nxt;
   logic            out_valid_nxt;
   logic [31:0]     col_in, col_out;
   logic            fwd_q;
`ifdef IMC_FWD_MODE_EN
   logic            fwd_q_nxt;
`else
   assign fwd_q = 1'b0;
`endif

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One column of the (Inv)MixColumns matrix; multiplies built from xtime chains.
   function automatic logic [31:0] mix_col(input logic [31:0] c, input logic fwd);
      logic [7:0] s   [4];
      logic [7:0] m2  [4];
      logic [7:0] m3  [4];
      logic [7:0] m9  [4];
      logic [7:0] m11 [4];
      logic [7:0] m13 [4];
      logic [7:0] m14 [4];
      logic [7:0] x4;
      logic [7:0] x8;
      for (int i = 0; i < 4; i++) begin
         s[i]   = c[31-8*i -: 8];
         m2[i]  = xtime(s[i]);
         x4     = xtime(m2[i]);
         x8     = xtime(x4);
         m3[i]  = m2[i] ^ s[i];
         m9[i]  = x8 ^ s[i];
         m11[i] = x8 ^ m2[i] ^ s[i];
         m13[i] = x8 ^ x4 ^ s[i];
         m14[i] = x8 ^ x4 ^ m2[i];
      end
      if (fwd)
         return {m2[0] ^ m3[1] ^ s[2]  ^ s[3],
                 s[0]  ^ m2[1] ^ m3[2] ^ s[3],
                 s[0]  ^ s[1]  ^ m2[2] ^ m3[3],
                 m3[0] ^ s[1]  ^ s[2]  ^ m2[3]};
      else
         return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                 m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                 m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                 m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col_cnt    <= '0;
         state_reg  <= '0;
         result_reg <= '0;
         out_valid  <= 1'b0;
`ifdef IMC_FWD_MODE_EN
         fwd_q      <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         col_cnt    <= col_cnt_nxt;
         state_reg  <= state_reg_nxt;
         result_reg <= result_reg_nxt;
         out_valid  <= out_valid_nxt;
`ifdef IMC_FWD_MODE_EN
         fwd_q      <= fwd_q_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt      = state;
      col_cnt_nxt    = col_cnt;
      state_reg_nxt  = state_reg;
      result_reg_nxt = result_reg;
      out_valid_nxt  = out_valid;
      col_in         = '0;
`ifdef IMC_FWD_MODE_EN
      fwd_q_nxt      = fwd_q;
`endif
      // Single shared column datapath, input selected by col_cnt.
      for (int c = 0; c < NUM_COLS; c++) begin
         if (col_cnt == CW'(c)) col_in = state_reg[127-32*c -: 32];
      end
      col_out = mix_col(col_in, fwd_q);

      case (state)
         IDLE: begin
            if (in_valid) begin
               state_reg_nxt = in_data;
               col_cnt_nxt   = '0;
               state_nxt     = BUSY;
`ifdef IMC_FWD_MODE_EN
               fwd_q_nxt     = fwd_mode;
`endif
            end
         end
         BUSY: begin
            for (int c = 0; c < NUM_COLS; c++) begin
               if (col_cnt == CW'(c)) result_reg_nxt[127-32*c -: 32] = col_out;
            end
            if (col_cnt == CW'(NUM_COLS-1)) begin
               state_nxt     = DONE;
               out_valid_nxt = 1'b1;
               col_cnt_nxt   = '0;
            end else begin
               col_cnt_nxt   = col_cnt + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign out_data = result_reg;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
`default_nettype none
// tb_inv_mix_columns_seq: directed vectors plus handshake, backpressure and reset corner cases.
module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic         fwd_sel = 1'b0;
`ifdef IMC_FWD_MODE_EN
   logic         fwd_mode;
   assign fwd_mode = fwd_sel;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_mix_columns_seq #(.NUM_COLS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef IMC_FWD_MODE_EN
      .fwd_mode  (fwd_mode),
`endif
      .out_data  (out_data),
      .busy      (busy)
   );

   typedef struct {
      logic [127:0] din;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] d, input logic fwd);
      logic [7:0] k [4];
      logic [7:0] s [4];
      logic [127:0] r = '0;
      if (fwd) begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
      else     begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) s[j] = d[127-32*c-8*j -: 8];
         for (int row = 0; row < 4; row++) begin
            logic [7:0] acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(k[(j - row + 4) % 4], s[j]);
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   // Present d until accepted; returns just after the accepting edge.
   task automatic accept(input logic [127:0] d);
      int n = 0;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Count edges after acceptance until out_valid, bounded.
   task automatic wait_out(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!out_valid && lat < 20);
   endtask

   task automatic handoff();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("handoff_out_valid", 128'(out_valid), 128'd0);
      chk("handoff_in_ready", 128'(in_ready), 128'd1);
   endtask

   initial begin
      int lat;
      logic [127:0] held;
      vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
      vecs[1] = '{128'h00000000_00000000_00000000_00000000, 128'h00000000_00000000_00000000_00000000};
      vecs[2] = '{128'hd4d4d4d5_00000000_ffffffff_01010101, 128'hddd9dfda_00000000_ffffffff_01010101};
      vecs[3] = '{128'h9fdc589d_8e4da1bc_c6c6c6c6_d4d4d4d5, 128'hf20a225c_db135345_c6c6c6c6_ddd9dfda};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("reset_in_ready", 128'(in_ready), 128'd1);
      chk("reset_out_valid", 128'(out_valid), 128'd0);
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_out_data", out_data, 128'd0);

      for (int i = 0; i < 4; i++) begin
         accept(vecs[i].din);
         chk("vec_busy", 128'(busy), 128'd1);
         wait_out(lat);
         chk("vec_latency", 128'(lat), 128'd4);
         chk("vec_data", out_data, vecs[i].exp);
         @(posedge clk);
         #1 chk("vec_returned_idle", 128'(in_ready), 128'd1);
      end

      // Backpressure with a stray in_valid during the stall.
      out_ready = 1'b0;
      accept(vecs[0].din);
      wait_out(lat);
      chk("bp_latency", 128'(lat), 128'd4);
      chk("bp_data", out_data, vecs[0].exp);
      held = out_data;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 4) begin in_valid = 1'b1; in_data = 128'h11112222_33334444_55556666_77778888; end
         if (i == 6) in_valid = 1'b0;
         if (i == 0 || i == 5 || i == 9) begin
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_data", out_data, held);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
         end
      end
      handoff();
      chk("bp_data_held_after", out_data, held);
      @(negedge clk);
      chk("bp_stay_idle", 128'(busy), 128'd0);

      // Back-to-back: second block held valid across the handoff edge.
      out_ready = 1'b0;
      accept(vecs[0].din);
      wait_out(lat);
      chk("b2b_first_data", out_data, vecs[0].exp);
      @(negedge clk);
      in_data = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 chk("b2b_idle_after_handoff", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1 chk("b2b_accepted_next", 128'(busy), 128'd1);
      in_valid = 1'b0;
      wait_out(lat);
      chk("b2b_latency", 128'(lat), 128'd4);
      chk("b2b_data", out_data, model(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 1'b0));
      @(posedge clk);
      #1;

      // Reset asserted with col_cnt == 2.
      accept(vecs[2].din);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 128'(out_valid), 128'd0);
      chk("midrst_busy", 128'(busy), 128'd0);
      chk("midrst_in_ready", 128'(in_ready), 128'd1);
      chk("midrst_out_data", out_data, 128'd0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid) chk("midrst_no_out_valid", 128'(out_valid), 128'd0);
      end
      chk("midrst_still_idle", 128'(busy), 128'd0);
      accept(vecs[3].din);
      wait_out(lat);
      chk("postrst_latency", 128'(lat), 128'd4);
      chk("postrst_data", out_data, vecs[3].exp);
      @(posedge clk);
      #1;

`ifdef IMC_FWD_MODE_EN
      fwd_sel = 1'b1;
      accept(128'hdb135345_f20a225c_01010101_c6c6c6c6);
      fwd_sel = 1'b0;
      wait_out(lat);
      chk("fwd_latency", 128'(lat), 128'd4);
      chk("fwd_data", out_data, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      @(posedge clk);
      #1;
      accept(vecs[0].din);
      wait_out(lat);
      chk("fwd_off_data", out_data, model(vecs[0].din, 1'b0));
      @(posedge clk);
      #1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
